// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multi-cycle ARM sequencer: states, datapath mux
// codes, condition codes and the supported data-processing commands.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_multicycle_ctrl_cond_check.sv
// Condition-code evaluator: maps Cond and registered NZCV to an execute flag.
module cond_check
    import arm_mc_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;
    assign {n, z, c, v} = Flags;

    // Decode all fifteen condition codes; 1111 never executes.
    always_comb begin
        CondEx = 1'b0;
        unique case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Moore sequencer for the multi-cycle ARM datapath: steps each instruction
// through fetch/decode/address/execute/writeback and owns the NZCV register.
module arm_multicycle_ctrl
    import arm_mc_pkg::*;
#(
    parameter bit         COND_EN     = 1'b1,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags,
    output logic [3:0]  State,
    output logic        InstrDone,
    output logic        Illegal
);

    state_t     state_q, state_d;
    logic [3:0] flags_q;

    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic       i_bit, s_bit, u_bit, l_bit, rd_pc;
    logic       cond_raw, cond_ex, dp_legal, is_cmp, is_arith;
    logic [1:0] dp_alu;
    logic       unused_instr_bits;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign i_bit = Instr[25];
    assign cmd   = Instr[24:21];
    assign s_bit = Instr[20];
    assign u_bit = Instr[23];
    assign l_bit = Instr[20];
    assign rd_pc = (Instr[15:12] == 4'hF);
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    assign is_cmp   = (cmd == CMD_CMP);
    assign is_arith = (cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp;
    assign dp_legal = (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
                      (cmd == CMD_ORR) || is_cmp;

    cond_check u_cond_check (
        .Cond   (cond),
        .Flags  (flags_q),
        .CondEx (cond_raw)
    );

    assign cond_ex = COND_EN ? cond_raw : 1'b1;

    // Data-processing command to ALU operation; CMP subtracts.
    always_comb begin
        dp_alu = ALU_ADD;
        unique case (cmd)
            CMD_SUB, CMD_CMP: dp_alu = ALU_SUB;
            CMD_AND:          dp_alu = ALU_AND;
            CMD_ORR:          dp_alu = ALU_ORR;
            default:          dp_alu = ALU_ADD;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NZCV register: logical ops refresh N/Z only, C/V keep their old value.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            flags_q <= RESET_FLAGS;
        end else if ((state_q == S_EXECR || state_q == S_EXECI) && (s_bit || is_cmp)) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (is_arith) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // Next-state and Moore output decode; Reset masks every write strobe.
    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RD2;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_8;
        RegSrc     = 2'b00;
        InstrDone  = 1'b0;
        Illegal    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (!cond_ex) begin
                    InstrDone = 1'b1;
                end else if (op == 2'b11 || (op == OP_DP && !dp_legal)) begin
                    Illegal   = 1'b1;
                    InstrDone = 1'b1;
                end else if (op == OP_MEM) begin
                    state_d = S_MEMADR;
                end else if (op == OP_DP) begin
                    state_d = i_bit ? S_EXECI : S_EXECR;
                end else begin
                    state_d = S_BRANCH;
                end
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_12;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
                state_d    = l_bit ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                RegSrc    = 2'b10;
                InstrDone = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                InstrDone = 1'b1;
                PCWrite   = rd_pc;
                RegWrite  = ~rd_pc;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                ALUControl = dp_alu;
                if (is_cmp) InstrDone = 1'b1;
                else        state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                InstrDone = 1'b1;
                PCWrite   = rd_pc;
                RegWrite  = ~rd_pc;
            end
            S_BRANCH: begin
                RegSrc    = 2'b01;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_24;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (Reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign Flags = flags_q;
    assign State = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: the stimulus process queues the
// hand-computed output vector for every cycle, the monitor compares at negedge.
module tb_arm_multicycle_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = '0;
    logic [3:0]  ALUFlags = '0;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  Flags, State;
    logic        InstrDone, Illegal;

    arm_multicycle_ctrl #(.COND_EN(1'b1), .RESET_FLAGS(4'b0000)) dut (
        .CLK(CLK), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags),
        .State(State), .InstrDone(InstrDone), .Illegal(Illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [25:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;

    // Field order: State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
    // ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, InstrDone, Illegal.
    function automatic logic [25:0] e(input logic [3:0] st, input logic pcw, adr, mw, irw, rw,
                                      input logic [1:0] rs, input logic sa,
                                      input logic [1:0] sb, ac, is, rsrc,
                                      input logic [3:0] fl, input logic dn, il);
        return {st, pcw, adr, mw, irw, rw, rs, sa, sb, ac, is, rsrc, fl, dn, il};
    endfunction

    function automatic logic [25:0] f_fetch(input logic [3:0] fl);
        return e(4'd0, 1, 0, 0, 1, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, fl, 0, 0);
    endfunction

    function automatic logic [25:0] f_decode(input logic [3:0] fl, input logic dn, il);
        return e(4'd1, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, fl, dn, il);
    endfunction

    task automatic cyc(input string name, input logic rst, input logic [31:0] ins,
                       input logic [3:0] af, input logic [25:0] v);
        exp_t x;
        Reset = rst;
        Instr = ins;
        ALUFlags = af;
        x.name = name;
        x.v = v;
        exp_q.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: one queued expectation per cycle, compared away from the clock edge.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            logic [25:0] act;
            x = exp_q.pop_front();
            act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, InstrDone, Illegal};
            checks++;
            if (act !== x.v) begin
                errors++;
                $display("FAIL %s: got %b required %b", x.name, act, x.v);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout required completion");
            $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
            $fatal(1);
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        // Reset cycle: FETCH decode but every write strobe masked.
        cyc("reset", 1, 32'h0, 4'h0,
            e(4'd0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0));

        // ADD R1,R2,R3 (no S): ALUFlags ignored.
        cyc("add_fetch", 0, 32'hE0821003, 4'hF, f_fetch(4'b0000));
        cyc("add_decode", 0, 32'hE0821003, 4'hF, f_decode(4'b0000, 0, 0));
        cyc("add_execr", 0, 32'hE0821003, 4'hF,
            e(4'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0));
        cyc("add_aluwb", 0, 32'hE0821003, 4'hF,
            e(4'd8, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0));

        // LDR R0,[R1,#4]
        cyc("ldr_fetch", 0, 32'hE5910004, 4'h0, f_fetch(4'b0000));
        cyc("ldr_decode", 0, 32'hE5910004, 4'h0, f_decode(4'b0000, 0, 0));
        cyc("ldr_memadr", 0, 32'hE5910004, 4'h0,
            e(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000, 0, 0));
        cyc("ldr_memrd", 0, 32'hE5910004, 4'h0,
            e(4'd3, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 0, 0));
        cyc("ldr_memwb", 0, 32'hE5910004, 4'h0,
            e(4'd4, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1, 0));

        // STR R0,[R1]
        cyc("str_fetch", 0, 32'hE5810000, 4'h0, f_fetch(4'b0000));
        cyc("str_decode", 0, 32'hE5810000, 4'h0, f_decode(4'b0000, 0, 0));
        cyc("str_memadr", 0, 32'hE5810000, 4'h0,
            e(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000, 0, 0));
        cyc("str_memwr", 0, 32'hE5810000, 4'h0,
            e(4'd5, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b10, 4'b0000, 1, 0));

        // BEQ with Z=0: skipped in two cycles.
        cyc("beq_nt_fetch", 0, 32'h0A000002, 4'h0, f_fetch(4'b0000));
        cyc("beq_nt_decode", 0, 32'h0A000002, 4'h0, f_decode(4'b0000, 1, 0));

        // SUBS R0,R0,R0 -> Flags 0110
        cyc("subs_fetch", 0, 32'hE0500000, 4'b0110, f_fetch(4'b0000));
        cyc("subs_decode", 0, 32'hE0500000, 4'b0110, f_decode(4'b0000, 0, 0));
        cyc("subs_execr", 0, 32'hE0500000, 4'b0110,
            e(4'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 0, 0));
        cyc("subs_aluwb", 0, 32'hE0500000, 4'b0000,
            e(4'd8, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0110, 1, 0));

        // BEQ taken on the freshly written Z.
        cyc("beq_t_fetch", 0, 32'h0A000002, 4'h0, f_fetch(4'b0110));
        cyc("beq_t_decode", 0, 32'h0A000002, 4'h0, f_decode(4'b0110, 0, 0));
        cyc("beq_t_branch", 0, 32'h0A000002, 4'h0,
            e(4'd9, 1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00, 2'b10, 2'b01, 4'b0110, 1, 0));

        // ANDS R0,R1,R3: N/Z from ALU (10), C/V held (10) -> 1010
        cyc("ands_fetch", 0, 32'hE0110003, 4'b1011, f_fetch(4'b0110));
        cyc("ands_decode", 0, 32'hE0110003, 4'b1011, f_decode(4'b0110, 0, 0));
        cyc("ands_execr", 0, 32'hE0110003, 4'b1011,
            e(4'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0110, 0, 0));
        cyc("ands_aluwb", 0, 32'hE0110003, 4'b0000,
            e(4'd8, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1010, 1, 0));

        // CMP R0,#5: three cycles, all four flags updated -> 0011
        cyc("cmp_fetch", 0, 32'hE3500005, 4'b0011, f_fetch(4'b1010));
        cyc("cmp_decode", 0, 32'hE3500005, 4'b0011, f_decode(4'b1010, 0, 0));
        cyc("cmp_execi", 0, 32'hE3500005, 4'b0011,
            e(4'd7, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b00, 2'b00, 4'b1010, 1, 0));

        // ADDEQ with Z=0: skipped
        cyc("addeq_fetch", 0, 32'h00821003, 4'h0, f_fetch(4'b0011));
        cyc("addeq_decode", 0, 32'h00821003, 4'h0, f_decode(4'b0011, 1, 0));

        // LDR PC,[R1,#-4]: SUB address, PCWrite instead of RegWrite
        cyc("ldrpc_fetch", 0, 32'hE511F004, 4'h0, f_fetch(4'b0011));
        cyc("ldrpc_decode", 0, 32'hE511F004, 4'h0, f_decode(4'b0011, 0, 0));
        cyc("ldrpc_memadr", 0, 32'hE511F004, 4'h0,
            e(4'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b01, 2'b01, 2'b00, 4'b0011, 0, 0));
        cyc("ldrpc_memrd", 0, 32'hE511F004, 4'h0,
            e(4'd3, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 0, 0));
        cyc("ldrpc_memwb", 0, 32'hE511F004, 4'h0,
            e(4'd4, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 1, 0));

        // Illegal encodings
        cyc("ill_op_fetch", 0, 32'hEC000000, 4'h0, f_fetch(4'b0011));
        cyc("ill_op_decode", 0, 32'hEC000000, 4'h0, f_decode(4'b0011, 1, 1));
        cyc("ill_mov_fetch", 0, 32'hE1A00001, 4'h0, f_fetch(4'b0011));
        cyc("ill_mov_decode", 0, 32'hE1A00001, 4'h0, f_decode(4'b0011, 1, 1));

        // ADDS with Reset asserted in EXECR: no flag update, back to FETCH with reset flags
        cyc("adds_fetch", 0, 32'hE0921003, 4'hF, f_fetch(4'b0011));
        cyc("adds_decode", 0, 32'hE0921003, 4'hF, f_decode(4'b0011, 0, 0));
        cyc("adds_execr_rst", 1, 32'hE0921003, 4'hF,
            e(4'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0011, 0, 0));
        cyc("post_rst_fetch", 0, 32'hE0821003, 4'hF, f_fetch(4'b0000));
        cyc("post_rst_decode", 0, 32'hE0821003, 4'hF, f_decode(4'b0000, 0, 0));

        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
